// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared states, port ids and command field layout for the memory access arbiter
package mem_arb_pkg;
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_ISSUE = 2'd1;
   localparam state_t ST_WAIT  = 2'd2;
   localparam state_t ST_DONE  = 2'd3;
   typedef enum logic {PORT_IF = 1'b0, PORT_DS = 1'b1} port_t;
   localparam int CMD_RW     = 2;
   localparam int CMD_SEL_HI = 1;
   localparam int CMD_SEL_LO = 0;
   localparam logic [1:0] SEL_RSVD = 2'b00;
   function automatic logic is_rsvd(input logic [2:0] cmd);
      return cmd[CMD_SEL_HI:CMD_SEL_LO] == SEL_RSVD;
   endfunction
endpackage

// File: rtl/mem_arb_rr2.sv
// mem_arb_rr2: two-requester round-robin picker, one-hot grant, bit 0 = IF, bit 1 = DS
module mem_arb_rr2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic [1:0] gnt_o
);
   // a lone requester always wins; on a tie the port not served last wins
   always_comb begin
      gnt_o[0] = req_i[0] & (~req_i[1] | (last_i == PORT_DS));
      gnt_o[1] = req_i[1] & (~req_i[0] | (last_i == PORT_IF));
   end
endmodule

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: shares one memory controller between the IF and DS ports, one transfer per grant
module mem_access_arbiter
   import mem_arb_pkg::*;
#(
   parameter int WORD = 16
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            if_req_i,
   input  logic [2:0]      if_cmd_i,
   input  logic [WORD-1:0] if_addr_i,
   input  logic [WORD-1:0] if_data_i,
   output logic            if_done_o,
   output logic            if_err_o,
   output logic [WORD-1:0] if_data_o,
   input  logic            ds_req_i,
   input  logic [2:0]      ds_cmd_i,
   input  logic [WORD-1:0] ds_addr_i,
   input  logic [WORD-1:0] ds_data_i,
   output logic            ds_done_o,
   output logic            ds_err_o,
   output logic [WORD-1:0] ds_data_o,
   output logic            mc_en_o,
   output logic [2:0]      mc_cmd_o,
   output logic [WORD-1:0] mc_addr_o,
   output logic [WORD-1:0] mc_data_o,
   input  logic            mc_busy_i,
   input  logic            mc_ack_i,
   input  logic [WORD-1:0] mc_data_i,
   output logic            busy_o
);
   state_t          state_q, state_d;
   port_t           win_q, last_q, nxt_win;
   logic            err_q, done, ack;
   logic [2:0]      cmd_q, nxt_cmd;
   logic [WORD-1:0] addr_q, wdata_q, if_rdata_q, ds_rdata_q;
   logic [1:0]      gnt;

   mem_arb_rr2 u_rr (
      .req_i ({ds_req_i, if_req_i}),
      .last_i(last_q),
      .gnt_o (gnt)
   );

   assign nxt_win = gnt[1] ? PORT_DS : PORT_IF;
   assign nxt_cmd = gnt[1] ? ds_cmd_i : if_cmd_i;
   assign ack     = mc_busy_i & mc_ack_i;

   // sequence one transfer; a reserved command bypasses the bus entirely
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (|gnt) state_d = is_rsvd(nxt_cmd) ? ST_DONE : ST_ISSUE;
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT:  if (ack) state_d = ST_DONE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // latch the winner's command at grant, capture read data on ack, rotate priority on completion
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         win_q      <= PORT_IF;
         last_q     <= PORT_DS;
         err_q      <= 1'b0;
         cmd_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         ds_rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE && |gnt) begin
            win_q   <= nxt_win;
            cmd_q   <= nxt_cmd;
            addr_q  <= gnt[1] ? ds_addr_i : if_addr_i;
            wdata_q <= gnt[1] ? ds_data_i : if_data_i;
            err_q   <= is_rsvd(nxt_cmd);
         end
         if (state_q == ST_WAIT && ack && !cmd_q[CMD_RW]) begin
            if (win_q == PORT_DS) ds_rdata_q <= mc_data_i;
            else if_rdata_q <= mc_data_i;
         end
         if (state_q == ST_DONE) last_q <= win_q;
      end
   end

   assign done      = state_q == ST_DONE;
   assign busy_o    = state_q != ST_IDLE;
   assign mc_en_o   = state_q == ST_ISSUE;
   assign mc_cmd_o  = cmd_q;
   assign mc_addr_o = addr_q;
   assign mc_data_o = wdata_q;
   assign if_done_o = done & (win_q == PORT_IF);
   assign ds_done_o = done & (win_q == PORT_DS);
   assign if_err_o  = if_done_o & err_q;
   assign ds_err_o  = ds_done_o & err_q;
   assign if_data_o = if_rdata_q;
   assign ds_data_o = ds_rdata_q;
endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter: directed and randomized check of the arbiter against a transaction timeline model
module tb_mem_access_arbiter;
   localparam int BIG = 1 << 30;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_i = 1'b1, if_req_i = 1'b0, ds_req_i = 1'b0;
   logic [2:0]  if_cmd_i = '0, ds_cmd_i = '0;
   logic [15:0] if_addr_i = '0, ds_addr_i = '0, if_data_i = '0, ds_data_i = '0;
   logic        mc_busy_i = 1'b0, mc_ack_i = 1'b0;
   logic [15:0] mc_data_i = '0;
   logic        if_done_o, if_err_o, ds_done_o, ds_err_o, mc_en_o, busy_o;
   logic [15:0] if_data_o, ds_data_o, mc_addr_o, mc_data_o;
   logic [2:0]  mc_cmd_o;

   mem_access_arbiter #(.WORD(16)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .if_req_i(if_req_i), .if_cmd_i(if_cmd_i), .if_addr_i(if_addr_i), .if_data_i(if_data_i),
      .if_done_o(if_done_o), .if_err_o(if_err_o), .if_data_o(if_data_o),
      .ds_req_i(ds_req_i), .ds_cmd_i(ds_cmd_i), .ds_addr_i(ds_addr_i), .ds_data_i(ds_data_i),
      .ds_done_o(ds_done_o), .ds_err_o(ds_err_o), .ds_data_o(ds_data_o),
      .mc_en_o(mc_en_o), .mc_cmd_o(mc_cmd_o), .mc_addr_o(mc_addr_o), .mc_data_o(mc_data_o),
      .mc_busy_i(mc_busy_i), .mc_ack_i(mc_ack_i), .mc_data_i(mc_data_i), .busy_o(busy_o)
   );

   int n_chk = 0, n_fail = 0;
   bit chk_on = 1'b0;

   bit          s_busy, s_ack, s_pend, s_fix, s_rand, s_spur, f_ack;
   int          s_cnt, s_w;
   logic [15:0] s_data, s_fixv, f_data;

   bit          m_tx, m_last = 1'b1, m_win, m_rsv;
   logic [2:0]  m_cmd;
   logic [15:0] m_addr, m_wd, m_ifd, m_dsd;
   int          cyc = 0, m_g = -10, m_done_c = BIG;
   bit          e_busy, e_en, e_ifd, e_dsd, e_ife, e_dse;

   task automatic chk(input string nm, input logic [15:0] a, input logic [15:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at t=%0t", nm, a, e, $time);
      end
   endtask

   task automatic slave_step();
      if (rst_i) begin
         s_busy = 0; s_ack = 0; s_pend = 0; s_cnt = 0;
      end else begin
         if (s_busy && s_ack) begin
            s_busy = 0; s_ack = 0;
         end else if (s_busy) begin
            if (s_cnt == 1) s_ack = 1;
            s_cnt--;
         end else s_ack = 0;
         if (s_pend) begin
            s_busy = 1;
            s_cnt = s_rand ? int'($urandom_range(3, 0)) : s_w;
            s_ack = (s_cnt == 0);
            s_pend = 0;
         end
         if (!s_busy && s_spur && $urandom_range(7, 0) == 0) s_ack = 1;
      end
      s_data = (s_busy && s_ack && s_fix) ? s_fixv : 16'($urandom);
      mc_busy_i = s_busy;
      mc_ack_i = f_ack | s_ack;
      mc_data_i = f_ack ? f_data : s_data;
      s_pend = mc_en_o && !rst_i;
   endtask

   task automatic model_step();
      if (rst_i) begin
         m_tx = 0; m_last = 1; m_win = 0; m_rsv = 0; m_cmd = '0; m_addr = '0; m_wd = '0;
         m_ifd = '0; m_dsd = '0; m_g = -10; m_done_c = BIG;
      end else if (!m_tx) begin
         if (if_req_i || ds_req_i) begin
            m_win = (if_req_i && ds_req_i) ? !m_last : ds_req_i;
            m_cmd = m_win ? ds_cmd_i : if_cmd_i;
            m_addr = m_win ? ds_addr_i : if_addr_i;
            m_wd = m_win ? ds_data_i : if_data_i;
            m_rsv = (m_cmd[1:0] == 2'b00);
            m_g = cyc;
            m_tx = 1;
            m_done_c = m_rsv ? cyc + 1 : BIG;
         end
      end else begin
         if (!m_rsv && m_done_c == BIG && cyc >= m_g + 2 && mc_busy_i && mc_ack_i) begin
            m_done_c = cyc + 1;
            if (!m_cmd[2]) begin
               if (m_win) m_dsd = mc_data_i;
               else m_ifd = mc_data_i;
            end
         end
         if (cyc == m_done_c) begin
            m_tx = 0; m_last = m_win;
         end
      end
      cyc++;
      e_busy = m_tx;
      e_en = m_tx && !m_rsv && cyc == m_g + 1;
      e_ifd = m_tx && cyc == m_done_c && !m_win;
      e_dsd = m_tx && cyc == m_done_c && m_win;
      e_ife = e_ifd && m_rsv;
      e_dse = e_dsd && m_rsv;
   endtask

   task automatic tick();
      slave_step();
      model_step();
      chk_on = 1;
      @(posedge clk);
      #3;
   endtask

   task automatic req_rand(inout logic req, inout logic [2:0] cmd, inout logic [15:0] addr,
                           inout logic [15:0] data, input logic done, input logic mine);
      if (done) begin
         req = $urandom_range(2, 0) != 0;
         cmd = 3'($urandom); addr = 16'($urandom); data = 16'($urandom);
      end else if (!req) begin
         if ($urandom_range(2, 0) == 0) begin
            req = 1; cmd = 3'($urandom); addr = 16'($urandom); data = 16'($urandom);
         end
      end else if (mine) begin
         cmd = 3'($urandom); addr = 16'($urandom); data = 16'($urandom);
      end
   endtask

   // every cycle, compare all outputs with the model's prediction
   always @(posedge clk) begin
      #1;
      if (chk_on) begin
         chk("busy_o", 16'(busy_o), 16'(e_busy));
         chk("mc_en_o", 16'(mc_en_o), 16'(e_en));
         chk("mc_cmd_o", 16'(mc_cmd_o), 16'(m_cmd));
         chk("mc_addr_o", mc_addr_o, m_addr);
         chk("mc_data_o", mc_data_o, m_wd);
         chk("if_done_o", 16'(if_done_o), 16'(e_ifd));
         chk("ds_done_o", 16'(ds_done_o), 16'(e_dsd));
         chk("if_err_o", 16'(if_err_o), 16'(e_ife));
         chk("ds_err_o", 16'(ds_err_o), 16'(e_dse));
         chk("if_data_o", if_data_o, m_ifd);
         chk("ds_data_o", ds_data_o, m_dsd);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ord[4];
      int nd, ov;
      s_w = 0; s_fix = 0; s_rand = 0; s_spur = 0; f_ack = 0; s_fixv = '0; f_data = '0;
      repeat (3) tick();
      rst_i = 0;
      tick();
      // zero-wait IF read
      if_req_i = 1; if_cmd_i = 3'b011; if_addr_i = 16'h0040; if_data_i = '0;
      s_fix = 1; s_fixv = 16'hBEEF; s_w = 0;
      tick();
      chk("t1_en_n1", 16'(mc_en_o), 16'h1);
      chk("t1_addr_n1", mc_addr_o, 16'h0040);
      if_addr_i = 16'hFFFF;
      tick();
      chk("t1_en_n2", 16'(mc_en_o), 16'h0);
      chk("t1_addr_n2", mc_addr_o, 16'h0040);
      tick();
      chk("t1_done_n3", 16'(if_done_o), 16'h1);
      chk("t1_data_n3", if_data_o, 16'hBEEF);
      if_req_i = 0;
      tick();
      chk("t1_done_n4", 16'(if_done_o), 16'h0);
      // DS write with two slave waits
      ds_req_i = 1; ds_cmd_i = 3'b111; ds_addr_i = 16'h1000; ds_data_i = 16'h1234; s_w = 2;
      tick();
      for (int c = 1; c <= 4; c++) begin
         chk("t2_addr", mc_addr_o, 16'h1000);
         chk("t2_wdata", mc_data_o, 16'h1234);
         chk("t2_early_done", 16'(ds_done_o), 16'h0);
         ds_addr_i = 16'($urandom); ds_data_i = 16'($urandom);
         tick();
      end
      chk("t2_done_n5", 16'(ds_done_o), 16'h1);
      chk("t2_ds_data", ds_data_o, 16'h0000);
      ds_req_i = 0;
      tick();
      // reserved DS command
      ds_req_i = 1; ds_cmd_i = 3'b100;
      tick();
      chk("t4_done_n1", 16'(ds_done_o), 16'h1);
      chk("t4_err_n1", 16'(ds_err_o), 16'h1);
      chk("t4_en_n1", 16'(mc_en_o), 16'h0);
      ds_req_i = 0;
      tick();
      chk("t4_en_n2", 16'(mc_en_o), 16'h0);
      chk("t4_busy_n2", 16'(busy_o), 16'h0);
      // spurious ack while idle
      f_ack = 1; f_data = 16'hAAAA;
      tick();
      f_ack = 0;
      tick();
      chk("t6_if_data", if_data_o, 16'hBEEF);
      chk("t6_ds_data", ds_data_o, 16'h0000);
      chk("t6_done", 16'({if_done_o, ds_done_o}), 16'h0);
      // reset while waiting on the bus
      s_fix = 0; s_w = 6;
      if_req_i = 1; if_cmd_i = 3'b011; if_addr_i = 16'h0050;
      repeat (3) tick();
      chk("t5_busy_wait", 16'(busy_o), 16'h1);
      rst_i = 1;
      tick();
      rst_i = 0;
      chk("t5_busy", 16'(busy_o), 16'h0);
      chk("t5_addr", mc_addr_o, 16'h0000);
      chk("t5_cmd", 16'(mc_cmd_o), 16'h0);
      chk("t5_if_data", if_data_o, 16'h0000);
      chk("t5_done", 16'({if_done_o, ds_done_o}), 16'h0);
      // continuous contention after reset
      ds_req_i = 1; ds_cmd_i = 3'b011; ds_addr_i = 16'h2000; s_w = 1;
      for (int i = 0; i < 4; i++) ord[i] = 2;
      nd = 0; ov = 0;
      for (int c = 0; c < 100 && nd < 4; c++) begin
         if (if_done_o && ds_done_o) ov++;
         if (if_done_o) begin
            ord[nd] = 0; nd++;
         end else if (ds_done_o) begin
            ord[nd] = 1; nd++;
         end
         tick();
      end
      for (int i = 0; i < 4; i++) chk($sformatf("t3_order%0d", i), 16'(ord[i]), 16'(i % 2));
      chk("t3_overlap", 16'(ov), 16'h0);
      if_req_i = 0; ds_req_i = 0;
      for (int c = 0; c < 12 && busy_o; c++) tick();
      chk("t3_idle", 16'(busy_o), 16'h0);
      // randomized traffic
      s_rand = 1; s_spur = 1;
      for (int i = 0; i < 3000; i++) begin
         rst_i = ($urandom_range(499, 0) == 0);
         req_rand(if_req_i, if_cmd_i, if_addr_i, if_data_i, if_done_o, m_tx && !m_win);
         req_rand(ds_req_i, ds_cmd_i, ds_addr_i, ds_data_i, ds_done_o, m_tx && m_win);
         tick();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
